// File: rtl/cla_pipe_add_if.sv
// cla_pipe_add_if: operand/result handshake bundle for cla_pipe_add.
//   master: drives in_valid, A, B, c0, sub, out_ready; sees in_ready and results.
//   slave : the adder side; drives in_ready, out_valid, S, cout, ovf, px, gx.
// Bit 1 of A/B/S is the LSB.
interface cla_pipe_add_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:1]   A;
  logic [WIDTH:1]   B;
  logic             c0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:1]   S;
  logic             cout;
  logic             ovf;
  logic             px;
  logic             gx;

  modport master (
    output in_valid, A, B, c0, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf, px, gx
  );

  modport slave (
    input  in_valid, A, B, c0, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf, px, gx
  );
endinterface

// File: rtl/cla_pipe_add.sv
// cla_pipe_add: pipelined carry-lookahead adder/subtractor.
// A WIDTH-bit add is split into NSTAGE = WIDTH/STAGE_W chunks, one chunk per
// pipeline stage, linked by a registered carry. Operands are skewed so chunk k
// is added k-1 cycles after acceptance; finished sum chunks ride along so the
// whole word appears together NSTAGE cycles after acceptance.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cla_pipe_add_if.slave (valid/ready in, valid/ready out,
//                A, B, c0, sub -> S, cout, ovf, px, gx)

// One STAGE_W chunk: bit p/g, 4-bit group P/G, group-level lookahead, then
// bit carries inside each group from the group carry-in.
module cla_pipe_add_chunk #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         pc,   // chunk propagate
  output logic         gc    // chunk generate (carry out with ci = 0)
);
  localparam int NG = W / 4;

  logic [W-1:0]  p, g, c;    // c[n] = carry into bit n
  logic [NG-1:0] gp, gg;
  logic [NG:0]   gcy;        // gcy[j] = carry into group j

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic prod, acc;
    prod = 1'b1;
    acc  = 1'b0;
    gp   = '0;
    gg   = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      acc   = 1'b0;
      prod  = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        acc  = acc | (g[4*j+i] & prod);
        prod = prod & p[4*j+i];
      end
      gg[j] = acc;
    end
  end

  // carry into group j+1 = OR over i<=j of G[i]&P[i+1..j], plus ci&P[0..j]
  always_comb begin
    logic prod, acc;
    prod   = 1'b1;
    acc    = 1'b0;
    gc     = 1'b0;
    gcy    = '0;
    gcy[0] = ci;
    for (int j = 0; j < NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int i = j; i >= 0; i--) begin
        acc  = acc | (gg[i] & prod);
        prod = prod & gp[i];
      end
      gc       = acc;        // final pass leaves the whole-chunk generate
      gcy[j+1] = acc | (ci & prod);
    end
  end

  always_comb begin
    logic prod, acc;
    prod = 1'b1;
    acc  = 1'b0;
    c    = '0;
    for (int n = 0; n < W; n++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int i = n - 1; i >= (n / 4) * 4; i--) begin
        acc  = acc | (g[i] & prod);
        prod = prod & p[i];
      end
      c[n] = acc | (gcy[n/4] & prod);
    end
  end

  assign s  = p ^ c;
  assign co = gcy[NG];
  assign pc = &p;
endmodule

module cla_pipe_add #(
  parameter int WIDTH   = 256,
  parameter int STAGE_W = 64
) (
  input logic           clk,
  input logic           rst_n,
  cla_pipe_add_if.slave bus
);
  localparam int NSTAGE = WIDTH / STAGE_W;

  if (WIDTH % STAGE_W != 0) begin : g_bad_width
    $error("cla_pipe_add: WIDTH must be a multiple of STAGE_W");
  end
  if (STAGE_W % 4 != 0) begin : g_bad_stage
    $error("cla_pipe_add: STAGE_W must be a multiple of 4");
  end

  logic              adv;
  logic [WIDTH:1]    be;
  logic              ce;
  logic [NSTAGE:1]   vld_pipe;

  // whole pipe moves together; a stalled output freezes every stage
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign be           = bus.sub ? ~bus.B : bus.B;
  assign ce           = bus.sub | bus.c0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= NSTAGE'({vld_pipe, bus.in_valid});

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_st
    // operand bits from this chunk upward; lower chunks were already consumed
    logic [WIDTH-(k-1)*STAGE_W-1:0] a_in, b_in;
    logic [STAGE_W-1:0]             s_c;
    logic                           ci, pxi, gxi, co, pc, gc;
    logic                           c_q, px_q, gx_q;
    logic [k*STAGE_W-1:0]           s_q;   // finished sum bits [k*STAGE_W:1]

    if (k == 1) begin : g_head
      assign a_in = bus.A;
      assign b_in = be;
      assign ci   = ce;
      assign pxi  = 1'b1;
      assign gxi  = 1'b0;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   s_q <= '0;
        else if (adv) s_q <= s_c;
    end else begin : g_link
      assign a_in = g_st[k-1].g_fw.a_q;
      assign b_in = g_st[k-1].g_fw.b_q;
      assign ci   = g_st[k-1].c_q;
      assign pxi  = g_st[k-1].px_q;
      assign gxi  = g_st[k-1].gx_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   s_q <= '0;
        else if (adv) s_q <= {s_c, g_st[k-1].s_q};
    end

    cla_pipe_add_chunk #(.W(STAGE_W)) u_chunk (
      .a  (a_in[STAGE_W-1:0]),
      .b  (b_in[STAGE_W-1:0]),
      .ci (ci),
      .s  (s_c),
      .co (co),
      .pc (pc),
      .gc (gc)
    );

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        c_q  <= 1'b0;
        px_q <= 1'b0;
        gx_q <= 1'b0;
      end else if (adv) begin
        c_q  <= co;
        px_q <= pc & pxi;
        gx_q <= gc | (pc & gxi);
      end

    if (k < NSTAGE) begin : g_fw
      logic [WIDTH-k*STAGE_W-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[WIDTH-(k-1)*STAGE_W-1:STAGE_W];
          b_q <= b_in[WIDTH-(k-1)*STAGE_W-1:STAGE_W];
        end
    end else begin : g_tail
      // carry into the MSB recovered as p ^ s at that bit
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= a_in[STAGE_W-1] ^ b_in[STAGE_W-1] ^ s_c[STAGE_W-1] ^ co;
    end
  end

  assign bus.out_valid = vld_pipe[NSTAGE];
  assign bus.S         = g_st[NSTAGE].s_q;
  assign bus.cout      = g_st[NSTAGE].c_q;
  assign bus.ovf       = g_st[NSTAGE].g_tail.ovf_q;
  assign bus.px        = g_st[NSTAGE].px_q;
  assign bus.gx        = g_st[NSTAGE].gx_q;
endmodule

// File: tb/tb_cla_pipe_add.sv
// tb_cla_pipe_add: two instances (256/64 and 16/4) driven with directed and
// random operands; results checked against an arithmetic model via FIFO
// scoreboards.
module tb_cla_pipe_add;
  localparam int W0 = 256, SW0 = 64, W1 = 16, SW1 = 4;

  typedef struct packed {
    logic [255:0] s;
    logic         cout, ovf, px, gx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_pipe_add_if #(.WIDTH(W0)) b0 ();
  cla_pipe_add_if #(.WIDTH(W1)) b1 ();

  cla_pipe_add #(.WIDTH(W0), .STAGE_W(SW0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  cla_pipe_add #(.WIDTH(W1), .STAGE_W(SW1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int           n_cmp = 0, n_err = 0, cyc = 0, rmode = 0;
  exp_t         q0[$], q1[$];
  logic         acc0, acc1, hold0, hold1;
  logic [255:0] sp0, sp1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [255:0] a, input logic [255:0] b,
                                 input logic c0, input logic sub, input int w);
    logic [256:0] m, be, raw, sum;
    exp_t e;
    m      = (257'd1 << w) - 257'd1;
    be     = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
    raw    = {1'b0, a} + be;
    sum    = raw + ((sub || c0) ? 257'd1 : 257'd0);
    e.s    = sum[255:0] & m[255:0];
    e.cout = sum[w];
    e.gx   = raw[w];
    e.px   = ((({1'b0, a}) ^ be) & m) == m;
    e.ovf  = (a[w-1] == be[w-1]) && (sum[w-1] != a[w-1]);
    return e;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = '0;
      2: r = 256'd1 << 255;
      3: r = r >> $urandom_range(0, 255);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic ordy_next();
    case (rmode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'(($urandom_range(0, 1)));
    endcase
  endfunction

  // called at negedge+2: inputs settled, outputs hold pre-edge values
  task automatic observe();
    exp_t e;
    if (rst_n) begin
      chk("rdy0", b0.in_ready, !(b0.out_valid && !b0.out_ready));
      if (hold0) chk("hold0", b0.S, sp0);
      if (q0.size() == 0) chk("idle0", b0.out_valid, 0);
      else if (b0.out_valid && b0.out_ready) begin
        e = q0.pop_front();
        chk("s0", b0.S, e.s);       chk("cout0", b0.cout, e.cout);
        chk("ovf0", b0.ovf, e.ovf); chk("px0", b0.px, e.px); chk("gx0", b0.gx, e.gx);
      end
      hold0 = b0.out_valid && !b0.out_ready;
      sp0   = b0.S;
      acc0  = b0.in_valid && b0.in_ready;
      if (acc0) q0.push_back(model(b0.A, b0.B, b0.c0, b0.sub, W0));

      chk("rdy1", b1.in_ready, !(b1.out_valid && !b1.out_ready));
      if (hold1) chk("hold1", 256'(b1.S), sp1);
      if (q1.size() == 0) chk("idle1", b1.out_valid, 0);
      else if (b1.out_valid && b1.out_ready) begin
        e = q1.pop_front();
        chk("s1", 256'(b1.S), e.s); chk("cout1", b1.cout, e.cout);
        chk("ovf1", b1.ovf, e.ovf); chk("px1", b1.px, e.px); chk("gx1", b1.gx, e.gx);
      end
      hold1 = b1.out_valid && !b1.out_ready;
      sp1   = 256'(b1.S);
      acc1  = b1.in_valid && b1.in_ready;
      if (acc1) q1.push_back(model(256'(b1.A), 256'(b1.B), b1.c0, b1.sub, W1));
    end
  endtask

  task automatic step();
    b0.out_ready = ordy_next();
    b1.out_ready = ordy_next();
    #1;
    observe();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int id, input logic [255:0] a, input logic [255:0] b,
                      input logic c0, input logic sub);
    int n;
    n = 0;
    if (id == 0) begin
      b0.A = a; b0.B = b; b0.c0 = c0; b0.sub = sub; b0.in_valid = 1'b1;
    end else begin
      b1.A = a[15:0]; b1.B = b[15:0]; b1.c0 = c0; b1.sub = sub; b1.in_valid = 1'b1;
    end
    do begin
      step();
      n++;
    end while (!(id == 0 ? acc0 : acc1) && n < 50);
    chk("accept", (id == 0 ? acc0 : acc1), 1);
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
  endtask

  task automatic lat_test(input int id, input logic [255:0] a, input logic [255:0] b,
                          input logic c0, input logic sub);
    int n;
    rmode = 0;
    send(id, a, b, c0, sub);
    n = 1;
    while (!(id == 0 ? b0.out_valid : b1.out_valid) && n < 20) begin
      step();
      n++;
    end
    chk(id == 0 ? "lat0" : "lat1", n, 4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain0", 256'(q0.size()), 0);
    chk("drain1", 256'(q1.size()), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, b0.out_valid, 0); chk({tag, "_s0"}, b0.S, 0);
    chk({tag, "_c0"}, b0.cout, 0);      chk({tag, "_o0"}, b0.ovf, 0);
    chk({tag, "_p0"}, b0.px, 0);        chk({tag, "_g0"}, b0.gx, 0);
    chk({tag, "_v1"}, b1.out_valid, 0); chk({tag, "_s1"}, 256'(b1.S), 0);
    chk({tag, "_p1"}, b1.px, 0);        chk({tag, "_g1"}, b1.gx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] r;
    rst_n = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0; sp0 = '0; sp1 = '0;
    b0.in_valid = 1'b0; b0.A = '0; b0.B = '0; b0.c0 = 1'b0; b0.sub = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.A = '0; b1.B = '0; b1.c0 = 1'b0; b1.sub = 1'b0; b1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    step();
    chk("rdy_init", b0.in_ready, 1);

    // all-ones + 0 + c0 wraps to zero with carry out
    lat_test(0, '1, '0, 1'b1, 1'b0);
    drain();

    rmode = 0;
    send(0, 256'd5, 256'd7, 1'b0, 1'b1);
    send(0, 256'd1 << 255, 256'd1, 1'b1, 1'b1);
    send(0, (256'd1 << 192) - 256'd1, 256'd1, 1'b0, 1'b0);
    drain();

    // back-to-back with a 1,0,0,1 out_ready pattern
    rmode = 1;
    for (int i = 1; i <= 10; i++) send(0, 256'(i), 256'(i), 1'b0, 1'b0);
    drain();

    // reset with three transactions in flight
    rmode = 0;
    send(0, 256'hdead_beef, 256'h1234, 1'b1, 1'b0);
    send(0, '1, '1, 1'b0, 1'b0);
    send(0, 256'd1 << 255, 256'd3, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    q0.delete(); q1.delete();
    hold0 = 1'b0; hold1 = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rdy_post_rst", b0.in_ready, 1);

    // narrow instance: 0xFFFF + 1 carries out through all four stages
    lat_test(1, 256'hffff, 256'h0001, 1'b0, 1'b0);
    drain();

    // random traffic on both instances with random backpressure
    rmode = 2;
    for (int t = 0; t < 300; t++) begin
      b0.in_valid = ($urandom_range(0, 9) < 7);
      b0.A = rnd256(); b0.B = rnd256();
      b0.c0 = 1'($urandom_range(0, 1)); b0.sub = 1'($urandom_range(0, 1));
      b1.in_valid = ($urandom_range(0, 9) < 7);
      r = rnd256(); b1.A = r[15:0];
      r = rnd256(); b1.B = r[15:0];
      b1.c0 = 1'($urandom_range(0, 1)); b1.sub = 1'($urandom_range(0, 1));
      step();
    end
    rmode = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
